sound_io_hub: RTL and testbench

Host-side I/O hub for a generic arcade sound board. It generalises the single command latch plus single DAC latch into a parametrised command FIFO from the main board to the sound CPU, NUM_DAC latched DAC channels with a registered mixer, and a fractional clock-enable generator for the speech chip (nominally 720 kHz). It sits between the main-board command port, the sound CPU address decode, and the audio output.

---
 rtl/sound_io_pkg.sv | 22 ++
 rtl/sound_cmd_fifo.sv | 101 ++++++++++
 rtl/sound_io_hub.sv | 116 +++++++++++
 tb/tb_sound_io_hub.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_io_pkg.sv
// sound_io_pkg: shared sizing helpers and constants for the sound I/O hub.
//   clog2_min1(n)       : ceil(log2(n)), never below 1 (select-field width)
//   mix_w(dac_w, n)     : mixer width that cannot overflow for n channels
//   SPEECH_INC_40MHZ    : phase increment giving ~720 kHz speech_ce at 40 MHz
package sound_io_pkg;

  localparam int unsigned SPEECH_INC_40MHZ = 1180;

  // Width of an index field for n items; a single item still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    if (n <= 2) begin
      return 1;
    end
    return int'($clog2(n));
  endfunction

  // Summing n channels of dac_w bits grows by clog2(n) bits.
  function automatic int unsigned mix_w(input int unsigned dac_w, input int unsigned n);
    return dac_w + int'($clog2(n));
  endfunction

endpackage

// File: rtl/sound_cmd_fifo.sv
// sound_cmd_fifo: command FIFO from the main board to the sound CPU.
// Owns storage, pointers, occupancy, the full/pending flags, the sticky
// overflow flag and the registered head word.
// Ports:
//   clk, reset_n    : clock, asynchronous active-low reset
//   cmd_wr/cmd_data : push strobe and word from the main board
//   snd_rd          : pop strobe from the sound CPU
//   ovf_clr         : clears cmd_ovf (an overflow in the same cycle wins)
//   cmd_full        : registered occupancy == FIFO_DEPTH
//   cmd_ovf         : sticky overflow flag
//   snd_cmd         : registered head word (holds last head when empty)
//   cmd_pending     : registered occupancy != 0
// FIFO_DEPTH must be a power of two and at least 2.
module sound_cmd_fifo #(
  parameter int unsigned CMD_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_wr,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             snd_rd,
  input  logic             ovf_clr,
  output logic             cmd_full,
  output logic             cmd_ovf,
  output logic [CMD_W-1:0] snd_cmd,
  output logic             cmd_pending
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CMD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic             empty_c;
  logic             full_c;
  logic             pop_c;
  logic             push_c;
  logic             ovf_set_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [PTR_W-1:0] rd_ptr_inc_c;
  logic [CMD_W-1:0] head_nxt_c;

  // Push/pop qualification: a pop frees a slot for a same-cycle push on a
  // full FIFO, while a pop on an empty FIFO is ignored.
  always_comb begin
    empty_c      = (count_q == '0);
    full_c       = (count_q == CNT_W'(FIFO_DEPTH));
    pop_c        = snd_rd & ~empty_c;
    push_c       = cmd_wr & (~full_c | pop_c);
    ovf_set_c    = cmd_wr & ~push_c;
    count_nxt_c  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    rd_ptr_inc_c = rd_ptr_q + PTR_W'(1);
  end

  // Head word after this edge; the word being pushed bypasses storage when
  // it becomes the head immediately.
  always_comb begin
    head_nxt_c = snd_cmd;
    if (count_nxt_c != '0) begin
      if (empty_c) begin
        head_nxt_c = cmd_data;
      end else if (pop_c) begin
        head_nxt_c = (count_q == CNT_W'(1)) ? cmd_data : mem_q[rd_ptr_inc_c];
      end
    end
  end

  // Storage, pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      cmd_full    <= 1'b0;
      cmd_pending <= 1'b0;
      cmd_ovf     <= 1'b0;
      snd_cmd     <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= cmd_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_inc_c;
      end
      count_q     <= count_nxt_c;
      cmd_full    <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
      cmd_pending <= (count_nxt_c != '0);
      cmd_ovf     <= ovf_set_c | (cmd_ovf & ~ovf_clr);
      snd_cmd     <= head_nxt_c;
    end
  end

endmodule

// File: rtl/sound_io_hub.sv
// sound_io_hub: host-side I/O hub for an arcade sound board.
// Command FIFO (main board -> sound CPU), NUM_DAC latched DAC channels with a
// registered mixer, and a phase-accumulator clock enable for the speech chip.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   cmd_wr, cmd_data        : command push from the main board
//   cmd_full, cmd_ovf       : FIFO full, sticky overflow (ovf_clr clears)
//   snd_rd, snd_cmd         : sound CPU pop strobe and registered head word
//   cmd_pending             : FIFO non-empty, level IRQ to the sound CPU
//   dac_we, dac_sel, dac_data : DAC channel write
//   audio_out               : registered mix of all channels (MIX_W bits)
//   speech_ce               : one-clk enable pulse per accumulator wrap
// Build option SOUND_IO_SIGNED_MIX_EN: channels are offset binary and the mix
// is a signed two's-complement sum; otherwise an unsigned sum.
module sound_io_hub
  import sound_io_pkg::*;
#(
  parameter  int unsigned CMD_W      = 8,
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned NUM_DAC    = 2,
  parameter  int unsigned DAC_W      = 8,
  parameter  int unsigned ACC_W      = 16,
  parameter  int unsigned SPEECH_INC = SPEECH_INC_40MHZ,
  localparam int unsigned SEL_W      = clog2_min1(NUM_DAC),
  localparam int unsigned MIX_W      = mix_w(DAC_W, NUM_DAC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_wr,
  input  logic [CMD_W-1:0] cmd_data,
  output logic             cmd_full,
  output logic             cmd_ovf,
  input  logic             ovf_clr,
  input  logic             snd_rd,
  output logic [CMD_W-1:0] snd_cmd,
  output logic             cmd_pending,
  input  logic             dac_we,
  input  logic [SEL_W-1:0] dac_sel,
  input  logic [DAC_W-1:0] dac_data,
  output logic [MIX_W-1:0] audio_out,
  output logic             speech_ce
);

  localparam logic [ACC_W:0] INC_EXT = (ACC_W + 1)'(SPEECH_INC);
`ifdef SOUND_IO_SIGNED_MIX_EN
  localparam logic [DAC_W-1:0] DAC_MSB = DAC_W'(1) << (DAC_W - 1);
`endif

  logic [DAC_W-1:0] dac_q [NUM_DAC];
  logic [MIX_W-1:0] sum_c;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W:0]   acc_sum_c;

  sound_cmd_fifo #(
    .CMD_W      (CMD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_wr      (cmd_wr),
    .cmd_data    (cmd_data),
    .snd_rd      (snd_rd),
    .ovf_clr     (ovf_clr),
    .cmd_full    (cmd_full),
    .cmd_ovf     (cmd_ovf),
    .snd_cmd     (snd_cmd),
    .cmd_pending (cmd_pending)
  );

  // DAC channel latches; an out-of-range select matches no channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_DAC; i++) begin
        dac_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_DAC; i++) begin
        if (dac_we && (dac_sel == SEL_W'(i))) begin
          dac_q[i] <= dac_data;
        end
      end
    end
  end

  // Channel sum; MIX_W has enough headroom that no saturation is needed.
  always_comb begin
    sum_c = '0;
    for (int unsigned i = 0; i < NUM_DAC; i++) begin
`ifdef SOUND_IO_SIGNED_MIX_EN
      // Flipping the MSB turns offset binary into two's complement.
      sum_c = sum_c + MIX_W'($signed(dac_q[i] ^ DAC_MSB));
`else
      sum_c = sum_c + MIX_W'(dac_q[i]);
`endif
    end
  end

  // Accumulator add with one extra bit; the carry is the enable pulse.
  always_comb begin
    acc_sum_c = {1'b0, acc_q} + INC_EXT;
  end

  // Registered mixer output and speech clock enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_out <= '0;
      acc_q     <= '0;
      speech_ce <= 1'b0;
    end else begin
      audio_out <= sum_c;
      acc_q     <= acc_sum_c[ACC_W-1:0];
      speech_ce <= acc_sum_c[ACC_W];
    end
  end

endmodule

// File: tb/tb_sound_io_hub.sv
// tb_sound_io_hub: directed and randomized checks of sound_io_hub against a
// queue/arithmetic reference model, compared on every falling clock edge.
module tb_sound_io_hub;

  localparam int unsigned NDAC  = 3;
  localparam int unsigned MIXW  = 10;
  localparam int unsigned ACCW  = 4;
  localparam int unsigned INC   = 3;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            reset_n;
  logic            cmd_wr;
  logic [7:0]      cmd_data;
  logic            ovf_clr;
  logic            snd_rd;
  logic            dac_we;
  logic [1:0]      dac_sel;
  logic [7:0]      dac_data;

  logic            cmd_full, cmd_ovf, cmd_pending, speech_ce;
  logic [7:0]      snd_cmd;
  logic [MIXW-1:0] audio_out;

  logic            z_full, z_ovf, z_pending, z_ce;
  logic [7:0]      z_snd;
  logic [MIXW-1:0] z_audio;

  sound_io_hub #(
    .CMD_W(8), .FIFO_DEPTH(DEPTH), .NUM_DAC(NDAC), .DAC_W(8),
    .ACC_W(ACCW), .SPEECH_INC(INC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .cmd_full(cmd_full), .cmd_ovf(cmd_ovf), .ovf_clr(ovf_clr), .snd_rd(snd_rd),
    .snd_cmd(snd_cmd), .cmd_pending(cmd_pending), .dac_we(dac_we),
    .dac_sel(dac_sel), .dac_data(dac_data), .audio_out(audio_out),
    .speech_ce(speech_ce)
  );

  sound_io_hub #(
    .CMD_W(8), .FIFO_DEPTH(DEPTH), .NUM_DAC(NDAC), .DAC_W(8),
    .ACC_W(ACCW), .SPEECH_INC(0)
  ) dut_nce (
    .clk(clk), .reset_n(reset_n), .cmd_wr(cmd_wr), .cmd_data(cmd_data),
    .cmd_full(z_full), .cmd_ovf(z_ovf), .ovf_clr(ovf_clr), .snd_rd(snd_rd),
    .snd_cmd(z_snd), .cmd_pending(z_pending), .dac_we(dac_we),
    .dac_sel(dac_sel), .dac_data(dac_data), .audio_out(z_audio),
    .speech_ce(z_ce)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned    mq[$];
  logic [7:0]      m_snd;
  bit              m_pend, m_full, m_ovf, m_ce;
  int              m_dac[NDAC];
  logic [MIXW-1:0] m_audio;
  longint          m_cyc;

  function automatic logic [MIXW-1:0] mix_of();
    int s = 0;
    for (int i = 0; i < int'(NDAC); i++) begin
`ifdef SOUND_IO_SIGNED_MIX_EN
      s += m_dac[i] - 128;
`else
      s += m_dac[i];
`endif
    end
    return MIXW'(s);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_snd = '0; m_pend = 0; m_full = 0; m_ovf = 0; m_ce = 0;
    for (int i = 0; i < int'(NDAC); i++) m_dac[i] = 0;
    m_audio = '0;
    m_cyc = 0;
  endtask

  task automatic model_step();
    bit pop, push;
    m_audio = mix_of();
    if (dac_we && dac_sel < NDAC) m_dac[dac_sel] = int'(dac_data);
    pop  = snd_rd && (mq.size() > 0);
    push = cmd_wr && ((mq.size() < DEPTH) || pop);
    if (cmd_wr && !push) m_ovf = 1;
    else if (ovf_clr)    m_ovf = 0;
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(cmd_data);
    if (mq.size() > 0) m_snd = mq[0];
    m_pend = (mq.size() > 0);
    m_full = (mq.size() == DEPTH);
    // One pulse each time INC*cycles crosses a multiple of 2^ACCW.
    m_cyc++;
    m_ce = ((m_cyc * INC) >> ACCW) != (((m_cyc - 1) * INC) >> ACCW);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        chk("cyc_snd_cmd",     32'(snd_cmd),     32'(m_snd));
        chk("cyc_cmd_pending", 32'(cmd_pending), 32'(m_pend));
        chk("cyc_cmd_full",    32'(cmd_full),    32'(m_full));
        chk("cyc_cmd_ovf",     32'(cmd_ovf),     32'(m_ovf));
        chk("cyc_audio_out",   32'(audio_out),   32'(m_audio));
        chk("cyc_speech_ce",   32'(speech_ce),   32'(m_ce));
        chk("cyc_zero_inc_ce", 32'(z_ce),        32'(0));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, then return them to idle just after the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                      input logic clr, input logic we, input logic [1:0] sel,
                      input logic [7:0] dd);
    cmd_wr = wr; cmd_data = d; snd_rd = rd; ovf_clr = clr;
    dac_we = we; dac_sel = sel; dac_data = dd;
    @(posedge clk); #1;
    cmd_wr = 0; snd_rd = 0; ovf_clr = 0; dac_we = 0;
  endtask

  task automatic push(input logic [7:0] d); step(1, d, 0, 0, 0, 0, 0); endtask
  task automatic pop();                     step(0, 0, 1, 0, 0, 0, 0); endtask
  task automatic idle();                    step(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic dacw(input logic [1:0] s, input logic [7:0] v); step(0, 0, 0, 0, 1, s, v); endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_snd_cmd"},   32'(snd_cmd),     0);
    chk({tag, "_pending"},   32'(cmd_pending), 0);
    chk({tag, "_full"},      32'(cmd_full),    0);
    chk({tag, "_ovf"},       32'(cmd_ovf),     0);
    chk({tag, "_audio"},     32'(audio_out),   0);
    chk({tag, "_speech_ce"}, 32'(speech_ce),   0);
  endtask

  int pulses;

  initial begin
    reset_n = 0; cmd_wr = 0; cmd_data = 0; ovf_clr = 0; snd_rd = 0;
    dac_we = 0; dac_sel = 0; dac_data = 0;
    repeat (3) @(negedge clk);
    checking = 1'b1;
    chk_all_zero("reset");
    reset_n = 1;

    // speech_ce: ACC_W=4, INC=3 pulses after cycles 6, 11, 16
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("speech_ce_c%0d", k), 32'(speech_ce), 32'(k == 6 || k == 11 || k == 16));
      if (speech_ce) pulses++;
    end
    chk("speech_pulse_count", 32'(pulses), 3);

    // FIFO order
    push(8'h11);
    chk("order_pending_1st", 32'(cmd_pending), 1);
    chk("order_head_11",     32'(snd_cmd), 32'h11);
    push(8'h22); push(8'h33);
    chk("order_head_still_11", 32'(snd_cmd), 32'h11);
    pop();  chk("order_head_22", 32'(snd_cmd), 32'h22);
    pop();  chk("order_head_33", 32'(snd_cmd), 32'h33);
    pop();
    chk("order_empty_pending", 32'(cmd_pending), 0);
    chk("order_hold_33",       32'(snd_cmd), 32'h33);

    // Full and overflow
    push(8'hA0); push(8'hA1); push(8'hA2);
    chk("ovf_not_full_3", 32'(cmd_full), 0);
    push(8'hA3);
    chk("ovf_full_4",  32'(cmd_full), 1);
    chk("ovf_clear_4", 32'(cmd_ovf), 0);
    push(8'hA4);
    chk("ovf_set",        32'(cmd_ovf), 1);
    chk("ovf_head_A0",    32'(snd_cmd), 32'hA0);
    step(1, 8'hA5, 0, 1, 0, 0, 0);
    chk("ovf_set_wins", 32'(cmd_ovf), 1);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("ovf_cleared", 32'(cmd_ovf), 0);

    // Push and pop together on a full FIFO
    step(1, 8'hB5, 1, 0, 0, 0, 0);
    chk("sim_full_stays", 32'(cmd_full), 1);
    chk("sim_no_ovf",     32'(cmd_ovf), 0);
    chk("sim_head_A1",    32'(snd_cmd), 32'hA1);
    pop(); pop(); pop();
    chk("sim_last_B5", 32'(snd_cmd), 32'hB5);
    pop();
    chk("sim_empty_pending", 32'(cmd_pending), 0);
    chk("sim_empty_hold",    32'(snd_cmd), 32'hB5);
    pop();
    chk("empty_pop_ignored", 32'(snd_cmd), 32'hB5);
    chk("empty_pop_pending", 32'(cmd_pending), 0);

    // Mixer
`ifdef SOUND_IO_SIGNED_MIX_EN
    dacw(0, 8'h80); dacw(1, 8'h80); dacw(2, 8'h80); idle();
    chk("mix_signed_zero", 32'(audio_out), 0);
    dacw(0, 8'h00); dacw(1, 8'h00); idle();
    chk("mix_signed_m256", 32'(audio_out), 32'h300);
    dacw(3, 8'h55); idle();
    chk("mix_signed_sel3_ignored", 32'(audio_out), 32'h300);
`else
    dacw(0, 8'hFF); dacw(1, 8'hFF);
    chk("mix_latency", 32'(audio_out), 32'h0FF);
    idle();
    chk("mix_1fe", 32'(audio_out), 32'h1FE);
    dacw(2, 8'h01); idle();
    chk("mix_sel2_accepted", 32'(audio_out), 32'h1FF);
    dacw(3, 8'h55); idle();
    chk("mix_sel3_ignored", 32'(audio_out), 32'h1FF);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) < 50), 8'($urandom), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 30),
           2'($urandom_range(0, 3)), 8'($urandom));
    end

    // Reset mid-operation with three queued words and live DACs
    for (int i = 0; i < 5; i++) pop();
    step(0, 0, 0, 1, 0, 0, 0);
    push(8'h01); push(8'h02); push(8'h03);
    dacw(0, 8'h12); dacw(1, 8'h34); idle();
    chk("pre_reset_pending", 32'(cmd_pending), 1);
    reset_n = 0;
    #1;
    chk_all_zero("midreset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
    chk("post_reset_pending", 32'(cmd_pending), 0);
`ifndef SOUND_IO_SIGNED_MIX_EN
    chk("post_reset_audio", 32'(audio_out), 0);
`endif
    repeat (5) idle();

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
